// File: rtl/serial_borrow_subtractor_if.sv
// Operand/result handshake bundle for serial_borrow_subtractor; the overflow wire exists only with SUB_OVERFLOW_FLAG_EN.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready between producer, block and consumer.
interface serial_borrow_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out
`ifdef SUB_OVERFLOW_FLAG_EN
        , input overflow
`endif
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out
`ifdef SUB_OVERFLOW_FLAG_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Serial a - b - borrow_in, CHUNK bits per cycle with lookahead borrows inside each slice; SUB_OVERFLOW_FLAG_EN adds a signed overflow flag.
// Latency: WIDTH/CHUNK cycles from accept to out_valid; one op per WIDTH/CHUNK+2 cycles.
// Backpressure: result is held in DONE until out_ready; in_ready is low outside IDLE.
module serial_borrow_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_borrow_subtractor_if.slave bus
);
    localparam int NSLICES = WIDTH / CHUNK;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("serial_borrow_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             borrow_q, borrow_out_q;
    logic             accept, last_slice;
    logic [CHUNK-1:0] sa, sb, sg, sp, sd;
    logic [CHUNK:0]   bw;
    logic             prop, acc;

    assign last_slice = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Each borrow into bit i+1 is an OR of generate terms propagated up to i,
    // plus the slice borrow-in propagated through the whole prefix.
    always_comb begin
        sa   = a_q[idx_q*CHUNK +: CHUNK];
        sb   = b_q[idx_q*CHUNK +: CHUNK];
        sg   = ~sa & sb;
        sp   = ~(sa ^ sb);
        bw   = '0;
        prop = 1'b1;
        acc  = 1'b0;
        bw[0] = borrow_q;
        for (int i = 0; i < CHUNK; i++) begin
            prop = 1'b1;
            acc  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (prop & sg[j]);
                prop = prop & sp[j];
            end
            bw[i+1] = acc | (prop & borrow_q);
        end
        sd = sa ^ sb ^ bw[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.borrow_in;
            idx_q    <= '0;
        end else if (state_q == RUN) begin
            diff_q[idx_q*CHUNK +: CHUNK] <= sd;
            borrow_q <= bw[CHUNK];
            idx_q    <= last_slice ? '0 : idx_q + 1'b1;
            if (last_slice) borrow_out_q <= bw[CHUNK];
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Only the top slice carries the sign bits; the flag is frozen with diff afterwards.
    always_ff @(posedge clk) begin
        if (rst)
            overflow_q <= 1'b0;
        else if (state_q == RUN && last_slice)
            overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sd[CHUNK-1] != a_q[WIDTH-1]);
    end

    assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor: arithmetic model plus directed vectors, CHUNK=4 and CHUNK=8 instances.
module tb_serial_borrow_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_borrow_subtractor_if #(.WIDTH(8)) bus  ();
    serial_borrow_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_borrow_subtractor #(.WIDTH(8), .CHUNK(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    serial_borrow_subtractor #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   r;
        int   s;
        exp_t e;
        r    = int'(a) - int'(b) - int'(bin);
        s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.d  = r[7:0];
        e.bo = (r < 0);
        e.ov = (s < -128) || (s > 127);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL model_unexpected_result: got out_valid=1, want no pending op");
                end else begin
                    check("model_diff", 32'(bus.diff), 32'(exp_q[0].d));
                    check("model_borrow_out", 32'(bus.borrow_out), 32'(exp_q[0].bo));
`ifdef SUB_OVERFLOW_FLAG_EN
                    check("model_overflow", 32'(bus.overflow), 32'(exp_q[0].ov));
`endif
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.borrow_in));
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, input logic chk_bw, input string name);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            if (chk_bw && cyc == 1)
                check({name, "_borrow_reg_after_slice0"}, 32'(dut.borrow_q), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_op(input string name, input logic [7:0] ed, input logic ebo,
                             input logic eov, input logic chk_bw);
        int cyc;
        wait_valid(cyc, chk_bw, name);
        check({name, "_latency"}, 32'(cyc), 32'd2);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_diff"}, 32'(bus.diff), 32'(ed));
        check({name, "_borrow_out"}, 32'(bus.borrow_out), 32'(ebo));
`ifdef SUB_OVERFLOW_FLAG_EN
        check({name, "_overflow"}, 32'(bus.overflow), 32'(eov));
`else
        if (eov === 1'bx) $display("note: %s overflow expectation undefined", name);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       bw;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs = '{
            '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0},
            '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0},
            '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
            '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1},
            '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
            '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0},
            '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0},
            '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0},
            '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0}
        };
        rst = 1'b1;
        bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.borrow_in  = 1'b0; bus.out_ready  = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.borrow_in = 1'b0; bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_borrow_out", 32'(bus.borrow_out), 32'd0);
        check("reset_in_ready_chunk8", 32'(bus8.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            finish_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].bw);
        end

        // Result held under backpressure while in_valid pulses arrive.
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_valid(cyc, 1'b0, "bp");
        check("bp_latency", 32'(cyc), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 8'hFF;
            bus.b        = 8'h00;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_diff", 32'(bus.diff), 32'h1E);
            check("bp_borrow_out", 32'(bus.borrow_out), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost_op", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of RUN discards the op.
        start_op(8'h44, 8'h11, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_run_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_run_diff", 32'(bus.diff), 32'd0);
        check("rst_run_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_run_borrow_out", 32'(bus.borrow_out), 32'd0);
        start_op(8'h22, 8'h33, 1'b0);
        finish_op("rst_recover", 8'hEF, 1'b1, 1'b0, 1'b0);

        // Single-slice instance: result one cycle after accept.
        bus8.a = 8'd5; bus8.b = 8'd3; bus8.borrow_in = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check("chunk8_running_out_valid", 32'(bus8.out_valid), 32'd0);
        @(posedge clk); #1;
        check("chunk8_out_valid", 32'(bus8.out_valid), 32'd1);
        check("chunk8_diff", 32'(bus8.diff), 32'h02);
        check("chunk8_borrow_out", 32'(bus8.borrow_out), 32'd0);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("chunk8_post_out_valid", 32'(bus8.out_valid), 32'd0);
        check("chunk8_post_in_ready", 32'(bus8.in_ready), 32'd1);

        check("model_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
